// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter datapath between two byte requesters. One byte
// is granted at a time: the winner is acknowledged with a one-cycle ready
// pulse, a coincident one-cycle tx_start launches the transmitter, and the
// arbiter then waits for tx_done. A frame watchdog recovers from a hung
// transmitter. After every frame, finished or timed out, an idle gap of
// GAP_CLOCKS cycles is enforced before the next grant.
//
// Build option:
//   UART_TX_ARB_ROUND_ROBIN_EN  defined   -> a tie goes to the requester that
//                                            was not granted last (req0 wins
//                                            the first tie after reset)
//                               undefined -> fixed priority, req0 always wins
//                                            a tie (req1 can starve)
//
// Ports:
//   i_clock        system clock, rising edge
//   i_resetL       asynchronous active-low reset
//   i_req0_valid   requester 0 holds a byte       i_req0_data  its byte
//   o_req0_ready   one-cycle ack: req0 byte consumed
//   i_req1_valid   requester 1 holds a byte       i_req1_data  its byte
//   o_req1_ready   one-cycle ack: req1 byte consumed
//   o_tx_start     one-cycle launch pulse to the transmitter
//   o_tx_data      byte presented to the transmitter, stable while waiting
//   i_tx_done      one-cycle pulse from the transmitter at end of stop bit
//   o_grant        one-hot current owner, 2'b00 when no frame is in flight
//   o_error        one-cycle pulse on watchdog expiry
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int DATA_WIDTH            = 8,
  parameter int CLOCKS_PER_BIT        = 434,
  parameter int BITS_PER_FRAME        = 10,
  parameter int GAP_CLOCKS            = 434,
  parameter int GAP_COUNTER_WIDTH     = 10,
  parameter int TIMEOUT_COUNTER_WIDTH = 13
) (
  input  logic                  i_clock,
  input  logic                  i_resetL,
  input  logic                  i_req0_valid,
  input  logic [DATA_WIDTH-1:0] i_req0_data,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic [DATA_WIDTH-1:0] i_req1_data,
  output logic                  o_req1_ready,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_tx_done,
  output logic [1:0]            o_grant,
  output logic                  o_error
);

  // The watchdog allows one bit time of slack beyond a full frame.
  localparam logic [TIMEOUT_COUNTER_WIDTH-1:0] TIMEOUT_LAST =
    TIMEOUT_COUNTER_WIDTH'(CLOCKS_PER_BIT * (BITS_PER_FRAME + 1) - 1);
  localparam logic [GAP_COUNTER_WIDTH-1:0] GAP_LAST =
    GAP_COUNTER_WIDTH'(GAP_CLOCKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_GAP       = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [TIMEOUT_COUNTER_WIDTH-1:0] wdog_q, wdog_d;
  logic [GAP_COUNTER_WIDTH-1:0]     gap_q, gap_d;
  logic [DATA_WIDTH-1:0]            tx_data_d;
  logic [1:0]                       grant_d;
  logic                             req0_ready_d, req1_ready_d;
  logic                             tx_start_d, error_d;
  logic                             pick_req1;

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  // Set when req1 owned the most recent grant; reset to 1 so that req0 takes
  // the first tie.
  logic last_req1_q, last_req1_d;

  assign pick_req1 = i_req1_valid && (!i_req0_valid || !last_req1_q);
`else
  assign pick_req1 = i_req1_valid && !i_req0_valid;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    wdog_d       = wdog_q;
    gap_d        = gap_q;
    tx_data_d    = o_tx_data;
    grant_d      = o_grant;
    req0_ready_d = 1'b0;
    req1_ready_d = 1'b0;
    tx_start_d   = 1'b0;
    error_d      = 1'b0;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    last_req1_d  = last_req1_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (i_req0_valid || i_req1_valid) begin
          state_d    = ST_WAIT_DONE;
          wdog_d     = '0;
          tx_start_d = 1'b1;
          if (pick_req1) begin
            tx_data_d    = i_req1_data;
            grant_d      = 2'b10;
            req1_ready_d = 1'b1;
          end else begin
            tx_data_d    = i_req0_data;
            grant_d      = 2'b01;
            req0_ready_d = 1'b1;
          end
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
          last_req1_d = pick_req1;
`endif
        end
      end

      ST_WAIT_DONE: begin
        // A done arriving on the terminal count still counts as a clean
        // finish, so it is tested first.
        if (i_tx_done || (wdog_q == TIMEOUT_LAST)) begin
          state_d = ST_GAP;
          grant_d = 2'b00;
          wdog_d  = '0;
          gap_d   = '0;
          error_d = !i_tx_done;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      state_q      <= ST_IDLE;
      wdog_q       <= '0;
      gap_q        <= '0;
      o_tx_data    <= '0;
      o_grant      <= 2'b00;
      o_req0_ready <= 1'b0;
      o_req1_ready <= 1'b0;
      o_tx_start   <= 1'b0;
      o_error      <= 1'b0;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
      last_req1_q  <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      gap_q        <= gap_d;
      o_tx_data    <= tx_data_d;
      o_grant      <= grant_d;
      o_req0_ready <= req0_ready_d;
      o_req1_ready <= req1_ready_d;
      o_tx_start   <= tx_start_d;
      o_error      <= error_d;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
      last_req1_q  <= last_req1_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter with default parameters. The bench
// plays the transmitter (drives i_tx_done) and both requesters. Inputs are
// driven and outputs sampled on the falling clock edge. Expected winners come
// from a small arbitration model (round-robin when
// UART_TX_ARB_ROUND_ROBIN_EN is defined, fixed priority otherwise); expected
// latencies come from cycle arithmetic on frame, watchdog and gap lengths.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int DW   = 8;
  localparam int CPB  = 434;
  localparam int BPF  = 10;
  localparam int GAP  = 434;
  localparam int WDOG = CPB * (BPF + 1);  // clocks from start cycle to error

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          tx_start, tx_done = 1'b0, error;
  logic [DW-1:0] tx_data;
  logic [1:0]    grant;

  int total = 0;
  int bad   = 0;
  int last_winner = 1;  // model pointer: requester granted most recently

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .i_clock      (clk),
    .i_resetL     (rst_n),
    .i_req0_valid (req0_valid),
    .i_req0_data  (req0_data),
    .o_req0_ready (req0_ready),
    .i_req1_valid (req1_valid),
    .i_req1_data  (req1_data),
    .o_req1_ready (req1_ready),
    .o_tx_start   (tx_start),
    .o_tx_data    (tx_data),
    .i_tx_done    (tx_done),
    .o_grant      (grant),
    .o_error      (error)
  );

  // Arbitration model: lone requester wins; a tie goes to req0 under fixed
  // priority, otherwise to whoever was not granted last.
  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && v1) return RR ? (1 - last) : 0;
    return v1 ? 1 : 0;
  endfunction

  function automatic logic [1:0] onehot(input int w);
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  // Wait up to limit falling edges for tx_start (or error); n = edges waited,
  // -1 if the bound expired.
  task automatic wait_for(input bit want_err, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (want_err ? error : tx_start) begin
        n = i;
        break;
      end
    end
  endtask

  // From the falling edge after edge k, have tx_done sampled at edge k+f and
  // return at the falling edge after it.
  task automatic end_frame(input int f);
    repeat (f - 1) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hAA;
    req1_valid = 1'b1; req1_data = 8'h55;
    repeat (868) @(negedge clk);
    total++;
    if ({req0_ready, req1_ready, tx_start, error, grant, tx_data} !== 14'd0) begin
      bad++;
      $display("FAIL reset_hold: outputs=%h want 0",
               {req0_ready, req1_ready, tx_start, error, grant, tx_data});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    last_winner = 1;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready, tx_start, error, grant, tx_data} !== 14'd0) begin
      bad++;
      $display("FAIL reset_idle: outputs=%h want 0",
               {req0_ready, req1_ready, tx_start, error, grant, tx_data});
    end
  endtask

  task automatic test_round_robin();
    int n, w;
    req0_valid = 1'b1; req0_data = 8'h41;
    req1_valid = 1'b1; req1_data = 8'h42;
    for (int i = 0; i < 4; i++) begin
      wait_for(1'b0, GAP + 20, n);
      w = pick(1'b1, 1'b1, last_winner);
      total++;
      if (n !== ((i == 0) ? 1 : GAP + 1)) begin
        bad++;
        $display("FAIL rr_latency[%0d]: got %0d want %0d", i, n, (i == 0) ? 1 : GAP + 1);
      end
      total++;
      if (grant !== onehot(w)) begin
        bad++;
        $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, onehot(w));
      end
      total++;
      if (tx_data !== ((w == 1) ? 8'h42 : 8'h41)) begin
        bad++;
        $display("FAIL rr_data[%0d]: got %h want %h", i, tx_data, (w == 1) ? 8'h42 : 8'h41);
      end
      total++;
      if ({req1_ready, req0_ready} !== onehot(w)) begin
        bad++;
        $display("FAIL rr_ready[%0d]: got %b want %b", i, {req1_ready, req0_ready}, onehot(w));
      end
      last_winner = w;
      if (i == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      end_frame(20);
    end
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    req0_valid = 1'b1; req0_data = 8'h61;
    wait_for(1'b0, 5, n);
    total++;
    if (n !== 1) begin
      bad++;
      $display("FAIL single_latency: got %0d want 1", n);
    end
    total++;
    if ({req0_ready, req1_ready, grant, tx_data} !== {1'b1, 1'b0, 2'b01, 8'h61}) begin
      bad++;
      $display("FAIL single_launch: r0=%b r1=%b grant=%b data=%h want 1 0 01 61",
               req0_ready, req1_ready, grant, tx_data);
    end
    req0_valid = 1'b0; req0_data = 8'hFF;
    last_winner = 0;
    @(negedge clk);
    total++;
    if ({req0_ready, tx_start, grant, tx_data} !== {1'b0, 1'b0, 2'b01, 8'h61}) begin
      bad++;
      $display("FAIL single_hold: r0=%b start=%b grant=%b data=%h want 0 0 01 61",
               req0_ready, tx_start, grant, tx_data);
    end
    end_frame(4339);  // done sampled 4340 clocks after the start edge
    total++;
    if ({grant, error} !== 3'b000) begin
      bad++;
      $display("FAIL single_done: grant=%b error=%b want 00 0", grant, error);
    end
    req0_valid = 1'b1; req0_data = 8'h62;
    wait_for(1'b0, GAP + 100, n);
    total++;
    if (n !== GAP + 1) begin
      bad++;
      $display("FAIL single_gap_spacing: got %0d want %0d", n, GAP + 1);
    end
    total++;
    if ({grant, tx_data} !== {2'b01, 8'h62}) begin
      bad++;
      $display("FAIL single_second: grant=%b data=%h want 01 62", grant, tx_data);
    end
    req0_valid = 1'b0;
    end_frame(10);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_watchdog();
    int n;
    req1_valid = 1'b1; req1_data = 8'h33;
    wait_for(1'b0, 5, n);
    total++;
    if ({n == 1, grant} !== {1'b1, 2'b10}) begin
      bad++;
      $display("FAIL wdog_launch: latency=%0d grant=%b want 1 10", n, grant);
    end
    req1_valid = 1'b0;
    last_winner = 1;
    wait_for(1'b1, WDOG + 500, n);
    total++;
    if (n !== WDOG) begin
      bad++;
      $display("FAIL wdog_expiry: got %0d want %0d", n, WDOG);
    end
    total++;
    if (grant !== 2'b00) begin
      bad++;
      $display("FAIL wdog_grant: got %b want 00", grant);
    end
    @(negedge clk);
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL wdog_pulse_width: error=%b want 0", error);
    end
    req0_valid = 1'b1; req0_data = 8'h44;
    wait_for(1'b0, GAP + 100, n);
    total++;
    if (n !== GAP) begin
      bad++;
      $display("FAIL wdog_gap: got %0d want %0d", n, GAP);
    end
    req0_valid = 1'b0;
    last_winner = 0;
    end_frame(30);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_coincident();
    int n;
    int err_seen;
    req0_valid = 1'b1; req0_data = 8'h55;
    wait_for(1'b0, 5, n);
    req0_valid = 1'b0;
    last_winner = 0;
    end_frame(WDOG);  // done lands on the watchdog terminal count
    err_seen = int'(error);
    total++;
    if (grant !== 2'b00) begin
      bad++;
      $display("FAIL coinc_grant: got %b want 00", grant);
    end
    @(negedge clk);
    err_seen += int'(error);
    total++;
    if (err_seen !== 0) begin
      bad++;
      $display("FAIL coinc_no_error: error cycles=%0d want 0", err_seen);
    end
    req1_valid = 1'b1; req1_data = 8'h5A;
    wait_for(1'b0, GAP + 100, n);
    total++;
    if ({n == GAP, grant, tx_data} !== {1'b1, 2'b10, 8'h5A}) begin
      bad++;
      $display("FAIL coinc_next: latency=%0d grant=%b data=%h want %0d 10 5a",
               n, grant, tx_data, GAP);
    end
    req1_valid = 1'b0;
    last_winner = 1;
    end_frame(15);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    req0_valid = 1'b1; req0_data = 8'hA5;
    wait_for(1'b0, 5, n);
    req0_valid = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({req0_ready, req1_ready, tx_start, error, grant, tx_data} !== 14'd0) begin
      bad++;
      $display("FAIL reset_mid: outputs=%h want 0",
               {req0_ready, req1_ready, tx_start, error, grant, tx_data});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_winner = 1;
    req1_valid = 1'b1; req1_data = 8'h7E;
    wait_for(1'b0, 5, n);
    total++;
    if ({n == 1, req1_ready, grant, tx_data} !== {1'b1, 1'b1, 2'b10, 8'h7E}) begin
      bad++;
      $display("FAIL reset_relaunch: latency=%0d r1=%b grant=%b data=%h want 1 1 10 7e",
               n, req1_ready, grant, tx_data);
    end
    req1_valid = 1'b0;
    end_frame(25);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_spurious();
    int n;
    int hits;
    for (int i = 0; i < 5; i++) begin
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      total++;
      if ({req0_ready, req1_ready, tx_start, error, grant} !== 6'd0) begin
        bad++;
        $display("FAIL spur_idle[%0d]: outputs=%b want 0", i,
                 {req0_ready, req1_ready, tx_start, error, grant});
      end
    end
    req0_valid = 1'b1; req0_data = 8'h11;
    wait_for(1'b0, 5, n);
    total++;
    if (n !== 1) begin
      bad++;
      $display("FAIL spur_idle_launch: got %0d want 1", n);
    end
    req0_valid = 1'b0;
    last_winner = 0;
    end_frame(12);
    // In the gap: a stray done and a requester that gives up before service.
    hits = 0;
    for (int g = 1; g <= GAP; g++) begin
      if (g == 100) tx_done = 1'b1;
      if (g == 101) tx_done = 1'b0;
      if (g == 250) begin req1_valid = 1'b1; req1_data = 8'h99; end
      if (g == 260) req1_valid = 1'b0;
      @(negedge clk);
      if (tx_start || req0_ready || req1_ready || error) hits++;
    end
    total++;
    if (hits !== 0) begin
      bad++;
      $display("FAIL spur_gap_quiet: active cycles=%0d want 0", hits);
    end
    req0_valid = 1'b1; req0_data = 8'h22;
    wait_for(1'b0, 50, n);
    total++;
    if ({n == 1, grant, tx_data} !== {1'b1, 2'b01, 8'h22}) begin
      bad++;
      $display("FAIL spur_gap_timing: latency=%0d grant=%b data=%h want 1 01 22",
               n, grant, tx_data);
    end
    req0_valid = 1'b0;
    end_frame(8);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_random();
    int n, w, f;
    bit v0, v1;
    logic [DW-1:0] d0, d1, exp_d;
    for (int i = 0; i < 10; i++) begin
      do begin
        v0 = 1'($urandom);
        v1 = 1'($urandom);
      end while (!v0 && !v1);
      d0 = DW'($urandom);
      d1 = DW'($urandom);
      req0_valid = v0; req0_data = d0;
      req1_valid = v1; req1_data = d1;
      w = pick(v0, v1, last_winner);
      exp_d = (w == 1) ? d1 : d0;
      wait_for(1'b0, 5, n);
      total++;
      if ({n == 1, grant, {req1_ready, req0_ready}, tx_data} !== {1'b1, onehot(w), onehot(w), exp_d}) begin
        bad++;
        $display("FAIL rand_launch[%0d]: v=%b%b latency=%0d grant=%b ready=%b data=%h want 1 %b %b %h",
                 i, v1, v0, n, grant, {req1_ready, req0_ready}, tx_data, onehot(w), onehot(w), exp_d);
      end
      last_winner = w;
      req0_valid = 1'b0; req1_valid = 1'b0;
      f = $urandom_range(1, 300);
      end_frame(f);
      total++;
      if ({grant, error} !== 3'b000) begin
        bad++;
        $display("FAIL rand_done[%0d]: grant=%b error=%b want 00 0", i, grant, error);
      end
      repeat (GAP) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_watchdog();
    test_coincident();
    test_reset_mid_frame();
    test_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
